pipelined_cla_adder: RTL and testbench
======================================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4 in range 4..64 (elaboration error otherwise).
REQ-002 Derived constant LAT = WIDTH/4, pipeline depth in cycles (one stage per 4-bit group).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set on a, b, cin, sub is valid.
REQ-006 in_ready  output  1  block can accept an operand set this cycle.
REQ-007 a  input  WIDTH  operand A (unsigned or two's complement).
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  0 = A+B+cin; 1 = A-B.
REQ-011 out_valid  output  1  sum/cout/ovf hold a valid result.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  carry out of MSB (sub=1: 1 = no borrow).
REQ-015 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-016 Effective operands: sub=0 -> B'=b, c0=cin; sub=1 -> B'=~b, c0=1.
REQ-017 Stage k (k=0..LAT-1) computes bits [4k+3:4k] with a 4-bit carry-lookahead group: per-bit generate/propagate, all four internal carries from G/P and group carry-in, no intra-group ripple.
REQ-018 Group carry-in of stage k is c0 for k=0, else the registered group carry-out of stage k-1.
REQ-019 Operand bits for groups not yet computed SHALL be delayed alongside; computed sum bits SHALL be carried forward unchanged.
REQ-020 Stage LAT-1 also registers carry into MSB and carry out of MSB to produce cout and ovf.
REQ-021 Each stage holds a valid bit; transfer in = in_valid && in_ready.
REQ-022 Global advance adv = !out_valid || out_ready; in_ready = adv (combinational); when adv=0 every stage register, incl. outputs, holds.
REQ-023 Latency: result of a transfer in cycle N is presented with out_valid=1 in cycle N+LAT if adv=1 throughout.
REQ-024 Throughput: one operand set per cycle with no stalls; results leave in acceptance order, none lost, none duplicated.
REQ-025 While out_valid=1 and out_ready=0, sum, cout, ovf SHALL be stable.
REQ-026 Bubbles (in_valid=0 while adv=1) propagate as invalid stages and never raise out_valid.
REQ-027 Arithmetic mod 2^WIDTH; sum = (a + B' + c0)[WIDTH-1:0], cout = bit WIDTH of that sum.
REQ-028 WIDTH=4: LAT=1, single registered CLA stage, same handshake.

Reset
REQ-029 rst_n=0 SHALL immediately clear all stage valid bits; out_valid=0, sum=0, cout=0, ovf=0.
REQ-030 in_ready SHALL be 1 while out_valid=0, including during reset.
REQ-031 Reset mid-operation discards all in-flight results; after release no out_valid until LAT cycles after a new transfer.
REQ-032 No operand set is accepted in a cycle where rst_n=0 at the clock edge.

Verification (WIDTH=16 unless noted, out_ready=1 unless noted)
REQ-033 a=0x0001, b=0x0002, cin=1, sub=0 -> 4 cycles later sum=0x0004, cout=0, ovf=0.
REQ-034 a=0xFFFF, b=0x0002, cin=1, sub=0 -> sum=0x0002, cout=1, ovf=0; a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-035 a=0x0006, b=0x0009, sub=1, cin=1 -> sum=0xFFFD, cout=0, ovf=0; a=0x0009, b=0x0006, sub=1 -> sum=0x0003, cout=1.
REQ-036 Back-to-back 6 transfers, out_ready=0 for 3 cycles on first result -> in_ready=0 those cycles, output held stable, all 6 results emitted in order, exactly once.
REQ-037 rst_n pulsed low with 2 results in flight -> out_valid=0 asynchronously, neither stale result ever appears; next transfer emerges after 4 cycles.
REQ-038 WIDTH=4 instance: a=6, b=9, cin=0 -> next cycle sum=15, cout=0; a=15, b=2, cin=1 -> sum=2, cout=1; random 10k vectors match a reference model for WIDTH=4,16,64.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one 4-bit carry-lookahead group per stage,
// valid/ready handshake with a single global advance enable.
module pipelined_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LAT = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in the range 4..64");
  end

  // Returns {group carry-out, 4 sum bits}; every carry is a flat G/P product term.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g, p, c;
    logic       co;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {co, p ^ c};
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  // NOTE: one advance enable freezes every stage at once; no per-stage ready is
  // needed and an unstalled pipe still takes one operand set per cycle.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_b_eff  = sub ? ~b : b;
  assign w_c0     = sub | cin;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    localparam int REM = WIDTH - 4 * k;

    logic [REM-1:0] w_a, w_b;
    logic           w_ci, w_vi;
    logic [4:0]     w_grp;
    logic [4*k+3:0] w_sum_nx;

    logic           r_valid;
    logic           r_co;
    logic [4*k+3:0] r_sum;

    if (k == 0) begin : g_head
      assign w_a      = a;
      assign w_b      = w_b_eff;
      assign w_ci     = w_c0;
      assign w_vi     = in_valid;
      assign w_sum_nx = w_grp[3:0];
    end else begin : g_tail
      assign w_a      = g_stage[k-1].g_fwd.r_a;
      assign w_b      = g_stage[k-1].g_fwd.r_b;
      assign w_ci     = g_stage[k-1].r_co;
      assign w_vi     = g_stage[k-1].r_valid;
      assign w_sum_nx = {w_grp[3:0], g_stage[k-1].r_sum};
    end

    assign w_grp = cla4(w_a[3:0], w_b[3:0], w_ci);

    // NOTE: data flops are cleared on reset as well, so sum/cout/ovf read 0
    // while rst_n is low, not just out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_co    <= 1'b0;
        r_sum   <= '0;
      end else if (w_adv) begin
        r_valid <= w_vi;
        r_co    <= w_grp[4];
        r_sum   <= w_sum_nx;
      end
    end

    if (k < LAT - 1) begin : g_fwd
      logic [REM-5:0] r_a, r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[REM-1:4];
          r_b <= w_b[REM-1:4];
        end
      end
    end else begin : g_out
      logic r_ovf;

      // Carry into the MSB is recovered as sum ^ a ^ b' of that bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_grp[4] ^ (w_grp[3] ^ w_a[3] ^ w_b[3]);
        end
      end
    end
  end

  assign out_valid = g_stage[LAT-1].r_valid;
  assign sum       = g_stage[LAT-1].r_sum;
  assign cout      = g_stage[LAT-1].r_co;
  assign ovf       = g_stage[LAT-1].g_out.r_ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: WIDTH=16 main instance plus WIDTH=4 and WIDTH=64
// instances, each with a scoreboard fed on accept and drained on output.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_out_m = 0;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t q_m[$];
  res_t q_s[$];
  res_t q_l[$];

  // WIDTH=16 instance
  logic        m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready, m_cout, m_ovf;
  logic [15:0] m_a, m_b, m_sum;
  // WIDTH=4 instance
  logic        s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready, s_cout, s_ovf;
  logic [3:0]  s_a, s_b, s_sum;
  // WIDTH=64 instance
  logic        l_in_valid, l_in_ready, l_cin, l_sub, l_out_valid, l_out_ready, l_cout, l_ovf;
  logic [63:0] l_a, l_b, l_sum;

  pipelined_cla_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .sum(m_sum), .cout(m_cout), .ovf(m_ovf)
  );

  pipelined_cla_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
  );

  pipelined_cla_adder #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .a(l_a), .b(l_b), .cin(l_cin), .sub(l_sub), .out_valid(l_out_valid),
    .out_ready(l_out_ready), .sum(l_sum), .cout(l_cout), .ovf(l_ovf)
  );

  // Reference: plain wide addition; overflow from operand/result sign rule.
  function automatic res_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                 input logic ci, input logic sb);
    logic [64:0] mask, xs, yb, t;
    res_t        r;
    mask   = (65'd1 << w) - 65'd1;
    xs     = {1'b0, x} & mask;
    yb     = sb ? (~{1'b0, y} & mask) : ({1'b0, y} & mask);
    t      = xs + yb + (sb ? 65'd1 : {64'd0, ci});
    r.sum  = t[63:0] & mask[63:0];
    r.cout = t[w];
    r.ovf  = (xs[w-1] == yb[w-1]) && (t[w-1] != xs[w-1]);
    return r;
  endfunction

  initial begin : mon_m
    res_t        e;
    logic        hold;
    logic [17:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          n_total++;
          if (m_out_valid !== 1'b1 || {m_cout, m_ovf, m_sum} !== held) begin
            n_bad++;
            $display("FAIL stall_hold16: got valid=%b word=%h, want valid=1 word=%h",
                     m_out_valid, {m_cout, m_ovf, m_sum}, held);
          end
        end
        if (m_in_valid && m_in_ready)
          q_m.push_back(model(16, {48'd0, m_a}, {48'd0, m_b}, m_cin, m_sub));
        if (m_out_valid && m_out_ready) begin
          n_out_m++;
          n_total++;
          if (q_m.size() == 0) begin
            n_bad++;
            $display("FAIL sb16_extra: got sum=%h with nothing pending", m_sum);
          end else begin
            e = q_m.pop_front();
            if (m_sum !== e.sum[15:0] || m_cout !== e.cout || m_ovf !== e.ovf) begin
              n_bad++;
              $display("FAIL sb16_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                       m_sum, m_cout, m_ovf, e.sum[15:0], e.cout, e.ovf);
            end
          end
        end
        hold = m_out_valid && !m_out_ready;
        held = {m_cout, m_ovf, m_sum};
      end
    end
  end

  initial begin : mon_s
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (s_in_valid && s_in_ready)
          q_s.push_back(model(4, {60'd0, s_a}, {60'd0, s_b}, s_cin, s_sub));
        if (s_out_valid && s_out_ready) begin
          n_total++;
          if (q_s.size() == 0) begin
            n_bad++;
            $display("FAIL sb4_extra: got sum=%h with nothing pending", s_sum);
          end else begin
            e = q_s.pop_front();
            if (s_sum !== e.sum[3:0] || s_cout !== e.cout || s_ovf !== e.ovf) begin
              n_bad++;
              $display("FAIL sb4_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                       s_sum, s_cout, s_ovf, e.sum[3:0], e.cout, e.ovf);
            end
          end
        end
      end
    end
  end

  initial begin : mon_l
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (l_in_valid && l_in_ready)
          q_l.push_back(model(64, l_a, l_b, l_cin, l_sub));
        if (l_out_valid && l_out_ready) begin
          n_total++;
          if (q_l.size() == 0) begin
            n_bad++;
            $display("FAIL sb64_extra: got sum=%h with nothing pending", l_sum);
          end else begin
            e = q_l.pop_front();
            if (l_sum !== e.sum || l_cout !== e.cout || l_ovf !== e.ovf) begin
              n_bad++;
              $display("FAIL sb64_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                       l_sum, l_cout, l_ovf, e.sum, e.cout, e.ovf);
            end
          end
        end
      end
    end
  end

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (m_out_valid !== 1'b0 || m_sum !== 16'h0 || m_cout !== 1'b0 || m_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async16: got valid=%b sum=%h cout=%b ovf=%b, want all 0",
               m_out_valid, m_sum, m_cout, m_ovf);
    end
    m_in_valid = 1'b1;
    m_a = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (m_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", m_in_ready);
    end
    n_total++;
    if (s_out_valid !== 1'b0 || l_out_valid !== 1'b0 || s_sum !== 4'h0 || l_sum !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_other: got v4=%b v64=%b s4=%h s64=%h, want 0",
               s_out_valid, l_out_valid, s_sum, l_sum);
    end
    m_in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      n_total++;
      if (m_out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_no_accept: got out_valid=%b want 0", m_out_valid);
      end
    end
  endtask

  typedef struct packed {
    logic [15:0] a, b;
    logic        ci, sb;
    logic [15:0] s;
    logic        co, ov;
  } dvec_t;

  task automatic test_directed;
    dvec_t dv [6];
    dv[0] = '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0};
    dv[1] = '{16'hFFFF, 16'h0002, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
    dv[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    dv[3] = '{16'h0006, 16'h0009, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    dv[4] = '{16'h0009, 16'h0006, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0};
    dv[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    for (int v = 0; v < 6; v++) begin
      @(posedge clk);
      #1;
      m_a = dv[v].a; m_b = dv[v].b; m_cin = dv[v].ci; m_sub = dv[v].sb;
      m_in_valid = 1'b1;
      @(posedge clk);
      #1 m_in_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        n_total++;
        if (i < 4) begin
          if (m_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL dir%0d_early: got out_valid=1 after %0d cycles, want 0", v, i);
          end
        end else if (m_out_valid !== 1'b1 || m_sum !== dv[v].s || m_cout !== dv[v].co ||
                     m_ovf !== dv[v].ov) begin
          n_bad++;
          $display("FAIL dir%0d: got v=%b sum=%h cout=%b ovf=%b, want v=1 sum=%h cout=%b ovf=%b",
                   v, m_out_valid, m_sum, m_cout, m_ovf, dv[v].s, dv[v].co, dv[v].ov);
        end
      end
    end
  endtask

  task automatic test_width4;
    logic [3:0] ta [2];
    logic [3:0] tb [2];
    logic       tc [2];
    logic [3:0] es [2];
    logic       ec [2];
    ta[0] = 4'd6;  tb[0] = 4'd9; tc[0] = 1'b0; es[0] = 4'd15; ec[0] = 1'b0;
    ta[1] = 4'd15; tb[1] = 4'd2; tc[1] = 1'b1; es[1] = 4'd2;  ec[1] = 1'b1;
    for (int v = 0; v < 2; v++) begin
      @(posedge clk);
      #1;
      s_a = ta[v]; s_b = tb[v]; s_cin = tc[v]; s_sub = 1'b0;
      s_in_valid = 1'b1;
      @(posedge clk);
      #1 s_in_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (s_out_valid !== 1'b1 || s_sum !== es[v] || s_cout !== ec[v] || s_ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL w4_dir%0d: got v=%b sum=%0d cout=%b ovf=%b, want v=1 sum=%0d cout=%b ovf=0",
                 v, s_out_valid, s_sum, s_cout, s_ovf, es[v], ec[v]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int start_out;
    int w;
    @(posedge clk);
    #1;
    start_out = n_out_m;
    fork
      begin : prod
        for (int i = 0; i < 6; i++) begin
          int   tries;
          logic took;
          tries = 0;
          took  = 1'b0;
          m_a = 16'(16'h1111 * (i + 1));
          m_b = 16'h0F0F ^ 16'(i);
          m_cin = i[0];
          m_sub = (i == 3);
          m_in_valid = 1'b1;
          while (!took && tries < 20) begin
            @(negedge clk);
            took = m_in_ready;
            @(posedge clk);
            #1;
            tries++;
          end
          n_total++;
          if (!took) begin
            n_bad++;
            $display("FAIL b2b_accept%0d: got no accept in 20 cycles, want accept", i);
          end
        end
        m_in_valid = 1'b0;
      end
      begin : cons
        int          cw;
        logic [17:0] held;
        cw = 0;
        while (m_out_valid !== 1'b1 && cw < 20) begin
          @(posedge clk);
          #1;
          cw++;
        end
        n_total++;
        if (m_out_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_first: got no out_valid in 20 cycles, want 1");
        end else begin
          m_out_ready = 1'b0;
          held = {m_cout, m_ovf, m_sum};
          repeat (3) begin
            @(negedge clk);
            n_total++;
            if (m_in_ready !== 1'b0 || m_out_valid !== 1'b1 || {m_cout, m_ovf, m_sum} !== held) begin
              n_bad++;
              $display("FAIL b2b_stall: got in_ready=%b v=%b word=%h, want 0 1 %h",
                       m_in_ready, m_out_valid, {m_cout, m_ovf, m_sum}, held);
            end
            @(posedge clk);
            #1;
          end
          m_out_ready = 1'b1;
        end
      end
    join
    w = 0;
    while ((q_m.size() != 0 || m_out_valid) && w < 30) begin
      @(posedge clk);
      #1;
      w++;
    end
    n_total++;
    if (n_out_m - start_out != 6 || q_m.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d results (%0d pending), want 6 (0 pending)",
               n_out_m - start_out, q_m.size());
    end
  endtask

  task automatic test_reset_midflight;
    int w;
    @(posedge clk);
    #1;
    m_a = 16'h1234; m_b = 16'h4321; m_cin = 1'b0; m_sub = 1'b0;
    m_in_valid = 1'b1;
    @(posedge clk);
    #1;
    m_a = 16'hABCD; m_b = 16'h0101; m_sub = 1'b1;
    @(posedge clk);
    #1 m_in_valid = 1'b0;
    w = 0;
    while (m_out_valid !== 1'b1 && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    n_total++;
    if (m_out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_setup: got out_valid=%b, want 1 before reset", m_out_valid);
    end
    #1 rst_n = 1'b0;
    m_in_valid = 1'b1;
    #1;
    n_total++;
    if (m_out_valid !== 1'b0 || m_sum !== 16'h0) begin
      n_bad++;
      $display("FAIL rst_mid_async: got v=%b sum=%h, want v=0 sum=0000", m_out_valid, m_sum);
    end
    q_m.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_in_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      n_total++;
      if (m_out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_mid_stale: got out_valid=1 sum=%h, want 0", m_sum);
      end
    end
    @(posedge clk);
    #1;
    m_a = 16'h0F0F; m_b = 16'h00F1; m_cin = 1'b1; m_sub = 1'b0;
    m_in_valid = 1'b1;
    @(posedge clk);
    #1 m_in_valid = 1'b0;
    w = 1;
    while (m_out_valid !== 1'b1 && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    n_total++;
    if (m_out_valid !== 1'b1 || w != 4) begin
      n_bad++;
      $display("FAIL rst_mid_latency: got v=%b after %0d cycles, want v=1 after 4", m_out_valid, w);
    end
  endtask

  task automatic test_random;
    int w;
    @(posedge clk);
    #1;
    for (int n = 0; n < 10000; n++) begin
      m_a = 16'($urandom); m_b = 16'($urandom);
      m_cin = 1'($urandom); m_sub = 1'($urandom);
      m_in_valid = ($urandom_range(0, 3) != 0);
      m_out_ready = ($urandom_range(0, 3) != 0);
      s_a = 4'($urandom); s_b = 4'($urandom);
      s_cin = 1'($urandom); s_sub = 1'($urandom);
      s_in_valid = ($urandom_range(0, 3) != 0);
      s_out_ready = ($urandom_range(0, 3) != 0);
      l_a = {$urandom, $urandom}; l_b = {$urandom, $urandom};
      l_cin = 1'($urandom); l_sub = 1'($urandom);
      l_in_valid = ($urandom_range(0, 3) != 0);
      l_out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    m_in_valid = 1'b0; s_in_valid = 1'b0; l_in_valid = 1'b0;
    m_out_ready = 1'b1; s_out_ready = 1'b1; l_out_ready = 1'b1;
    w = 0;
    while ((q_m.size() != 0 || q_s.size() != 0 || q_l.size() != 0) && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    n_total++;
    if (q_m.size() != 0 || q_s.size() != 0 || q_l.size() != 0) begin
      n_bad++;
      $display("FAIL rand_drain: got pending %0d/%0d/%0d, want 0/0/0",
               q_m.size(), q_s.size(), q_l.size());
    end
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: time limit hit, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_n = 1'b1;
    m_in_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_out_ready = 1'b1;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0; s_out_ready = 1'b1;
    l_in_valid = 1'b0; l_a = '0; l_b = '0; l_cin = 1'b0; l_sub = 1'b0; l_out_ready = 1'b1;
    test_reset;
    test_directed;
    test_width4;
    test_back_to_back;
    test_reset_midflight;
    test_random;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
